// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared constants and helpers for the UART receive path.
//   - Default widths for the prescale input and the data-bit counter.
//   - Default prescale used after reset, and the set of legal prescale
//     values (even, 4..32; the common ratios are 4, 8, 16 and 32).
//   - Offsets of the three majority-vote sample edges and of the frame
//     finish point, relative to the bit midpoint P/2.
package uart_rx_pkg;

    localparam int PRESC_W_DEF   = 6;
    localparam int BIT_CNT_W_DEF = 3;
    localparam int DEF_PRESC_VAL = 8;

    localparam int PRESC_4   = 4;
    localparam int PRESC_8   = 8;
    localparam int PRESC_16  = 16;
    localparam int PRESC_32  = 32;
    localparam int PRESC_MIN = PRESC_4;
    localparam int PRESC_MAX = PRESC_32;

    // Edge offsets relative to P/2.
    localparam int SAMP_OFS_EARLY = -1;
    localparam int SAMP_OFS_MID   = 0;
    localparam int SAMP_OFS_LATE  = 1;
    localparam int FINISH_OFS     = 2;

    // A prescale is legal when it is even and inside [PRESC_MIN, PRESC_MAX].
    function automatic logic presc_is_legal(input int unsigned p);
        return (p[0] == 1'b0) && (p >= PRESC_MIN) && (p <= PRESC_MAX);
    endfunction

endpackage

// File: rtl/ebc_mod_counter.sv
// ebc_mod_counter
// Generic modulo counter with synchronous clear.
//   MC_CLK    in   clock
//   MC_RST    in   synchronous active-high reset (count -> 0)
//   MC_clr    in   clear request, wins over MC_inc
//   MC_inc    in   advance by one; at MC_limit the count wraps to 0
//   MC_limit  in   last count value before wrapping
//   MC_cnt    out  current count
module ebc_mod_counter #(
    parameter int W = 6
) (
    input  logic         MC_CLK,
    input  logic         MC_RST,
    input  logic         MC_clr,
    input  logic         MC_inc,
    input  logic [W-1:0] MC_limit,
    output logic [W-1:0] MC_cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge MC_CLK) begin
        if (MC_RST) begin
            cnt_q <= '0;
        end else if (MC_clr) begin
            cnt_q <= '0;
        end else if (MC_inc) begin
            if (cnt_q == MC_limit) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + W'(1);
            end
        end
    end

    assign MC_cnt = cnt_q;

endmodule

// File: rtl/edge_bit_counter.sv
// edge_bit_counter
// Timing source for the UART receive controller. Counts oversampling edges
// inside each serial bit and counts received data bits, and derives the
// end-of-bit, frame-finish and mid-bit sample strobes.
//
// Optional build macro: EBC_PRESC_CHECK_EN
//   defined   - prescale is checked on load; an illegal value loads
//               DEF_PRESC instead and raises EBC_presc_err until the next
//               legal load.
//   undefined - prescale is loaded unchecked; EBC_presc_err is tied 0.
//
// Ports
//   EBC_CLK              in   oversampling clock
//   EBC_RST              in   synchronous active-high reset
//   EBC_PRESCALE         in   edges per bit (latched while edge counting idle)
//   EBC_edge_cnt_enable  in   edge counter run enable
//   EBC_bit_cnt_enable   in   bit counter run enable
//   EBC_edge_cnt         out  edge index within the current bit
//   EBC_bit_cnt          out  data bit index
//   EBC_EdgeFinish       out  last edge of the current bit
//   EBC_FINISH           out  frame finish point (edge P/2+2)
//   EBC_samp_strb        out  one of the three majority-vote sample edges
//   EBC_presc_err        out  last prescale load was illegal
//
// Handshake: there is no backpressure. Every strobe is a single-cycle
// qualifier, combinational from the counter registers and the enables, and
// is valid in the cycle it is high; the consumer must act in that cycle.
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W   = PRESC_W_DEF,
    parameter int BIT_CNT_W = BIT_CNT_W_DEF,
    parameter int DEF_PRESC = DEF_PRESC_VAL
) (
    input  logic                 EBC_CLK,
    input  logic                 EBC_RST,
    input  logic [PRESC_W-1:0]   EBC_PRESCALE,
    input  logic                 EBC_edge_cnt_enable,
    input  logic                 EBC_bit_cnt_enable,
    output logic [PRESC_W-1:0]   EBC_edge_cnt,
    output logic [BIT_CNT_W-1:0] EBC_bit_cnt,
    output logic                 EBC_EdgeFinish,
    output logic                 EBC_FINISH,
    output logic                 EBC_samp_strb,
    output logic                 EBC_presc_err
);

    localparam logic [PRESC_W-1:0] DEF_P = PRESC_W'(DEF_PRESC);

    logic [PRESC_W-1:0]   presc_q;
    logic [PRESC_W-1:0]   presc_last;
    logic [PRESC_W-1:0]   presc_half;
    logic [PRESC_W-1:0]   samp_early;
    logic [PRESC_W-1:0]   samp_mid;
    logic [PRESC_W-1:0]   samp_late;
    logic [PRESC_W-1:0]   finish_edge;
    logic [PRESC_W-1:0]   edge_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 edge_finish;

    // Prescale latch: follows the input only while edge counting is idle,
    // so a change during a frame takes effect at the next idle cycle.
`ifdef EBC_PRESC_CHECK_EN
    logic presc_err_q;
    logic presc_ok;

    assign presc_ok = presc_is_legal(32'(EBC_PRESCALE));

    always_ff @(posedge EBC_CLK) begin
        if (EBC_RST) begin
            presc_q     <= DEF_P;
            presc_err_q <= 1'b0;
        end else if (!EBC_edge_cnt_enable) begin
            if (presc_ok) begin
                presc_q     <= EBC_PRESCALE;
                presc_err_q <= 1'b0;
            end else begin
                presc_q     <= DEF_P;
                presc_err_q <= 1'b1;
            end
        end
    end

    assign EBC_presc_err = presc_err_q;
`else
    always_ff @(posedge EBC_CLK) begin
        if (EBC_RST) begin
            presc_q <= DEF_P;
        end else if (!EBC_edge_cnt_enable) begin
            presc_q <= EBC_PRESCALE;
        end
    end

    assign EBC_presc_err = 1'b0;
`endif

    assign presc_last  = presc_q - PRESC_W'(1);
    assign presc_half  = presc_q >> 1;
    assign samp_early  = presc_half + PRESC_W'(SAMP_OFS_EARLY);
    assign samp_mid    = presc_half + PRESC_W'(SAMP_OFS_MID);
    assign samp_late   = presc_half + PRESC_W'(SAMP_OFS_LATE);
    assign finish_edge = presc_half + PRESC_W'(FINISH_OFS);

    // Edge counter: runs 0..P-1 while enabled, held at 0 while disabled.
    ebc_mod_counter #(.W(PRESC_W)) u_edge_cnt (
        .MC_CLK   (EBC_CLK),
        .MC_RST   (EBC_RST),
        .MC_clr   (~EBC_edge_cnt_enable),
        .MC_inc   (EBC_edge_cnt_enable),
        .MC_limit (presc_last),
        .MC_cnt   (edge_cnt)
    );

    assign edge_finish = EBC_edge_cnt_enable && (edge_cnt == presc_last);

    // Bit counter: steps once per finished bit and wraps naturally at its
    // full-scale value. Dropping the enable clears it even if a bit is
    // finishing in the same cycle.
    ebc_mod_counter #(.W(BIT_CNT_W)) u_bit_cnt (
        .MC_CLK   (EBC_CLK),
        .MC_RST   (EBC_RST),
        .MC_clr   (~EBC_bit_cnt_enable),
        .MC_inc   (edge_finish),
        .MC_limit ({BIT_CNT_W{1'b1}}),
        .MC_cnt   (bit_cnt)
    );

    assign EBC_edge_cnt   = edge_cnt;
    assign EBC_bit_cnt    = bit_cnt;
    assign EBC_EdgeFinish = edge_finish;
    assign EBC_samp_strb  = EBC_edge_cnt_enable &&
                            ((edge_cnt == samp_early) ||
                             (edge_cnt == samp_mid)   ||
                             (edge_cnt == samp_late));
    // Emitted in every bit; the receive FSM only honours it in its stop
    // state, which lets it return to idle before the stop bit ends.
    assign EBC_FINISH     = EBC_edge_cnt_enable && (edge_cnt == finish_edge);

endmodule

// File: tb/tb_edge_bit_counter.sv
// Testbench for edge_bit_counter. Randomised and directed stimulus; expected
// outputs come from a cycle-count model of the timing rules.
module tb_edge_bit_counter;

    localparam int PW = 6;
    localparam int BW = 3;
    localparam int EW = 1 + 1 + 1 + 1 + BW + PW;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] presc;
    logic          een;
    logic          ben;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          edge_finish;
    logic          finish;
    logic          samp_strb;
    logic          presc_err;

    // clock / reset
    always #5 clk = ~clk;

    edge_bit_counter dut (
        .EBC_CLK             (clk),
        .EBC_RST             (rst),
        .EBC_PRESCALE        (presc),
        .EBC_edge_cnt_enable (een),
        .EBC_bit_cnt_enable  (ben),
        .EBC_edge_cnt        (edge_cnt),
        .EBC_bit_cnt         (bit_cnt),
        .EBC_EdgeFinish      (edge_finish),
        .EBC_FINISH          (finish),
        .EBC_samp_strb       (samp_strb),
        .EBC_presc_err       (presc_err)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model: run_len = consecutive enabled cycles so far,
    // bits_done = bits finished while the bit enable stayed high
    int p_lat     = 8;
    int run_len   = 0;
    int bits_done = 0;
    bit err_m     = 1'b0;

    function automatic bit legal_p(input int p);
        return (p % 2 == 0) && (p >= 4) && (p <= 32);
    endfunction

    function automatic int pick_presc();
`ifdef EBC_PRESC_CHECK_EN
        if ($urandom_range(0, 5) == 0) return int'($urandom_range(0, 63));
        return 2 * int'($urandom_range(2, 16));
`else
        return 2 * int'($urandom_range(2, 31));
`endif
    endfunction

    // driver: one clock cycle of inputs, expected outputs pushed for it
    task automatic cycle(input bit r, input int p, input bit e, input bit b);
        int ec;
        int half;
        bit ef;
        bit fin;
        bit smp;
        @(negedge clk);
        rst   = r;
        presc = PW'(p);
        een   = e;
        ben   = b;
        ec    = run_len % p_lat;
        half  = p_lat / 2;
        ef    = e && (ec == p_lat - 1);
        smp   = e && (ec >= half - 1) && (ec <= half + 1);
        fin   = e && (ec == half + 2);
        exp_q.push_back({err_m, smp, fin, ef, BW'(bits_done % 8), PW'(ec)});
        if (r) begin
            run_len   = 0;
            bits_done = 0;
            p_lat     = 8;
            err_m     = 1'b0;
        end else begin
            run_len = e ? run_len + 1 : 0;
            if (!b) bits_done = 0;
            else if (ef) bits_done = bits_done + 1;
            if (!e) begin
`ifdef EBC_PRESC_CHECK_EN
                if (legal_p(p)) begin
                    p_lat = p;
                    err_m = 1'b0;
                end else begin
                    p_lat = 8;
                    err_m = 1'b1;
                end
`else
                p_lat = p;
`endif
            end
        end
    endtask

    task automatic run(input int n, input bit r, input int p, input bit e, input bit b);
        for (int i = 0; i < n; i++) cycle(r, p, e, b);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // monitor: every cycle is an output beat; sampled mid-low-phase
    always @(negedge clk) begin
        logic [EW-1:0] x;
        #3;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("edge_cnt",   int'(edge_cnt),    int'(x[PW-1:0]));
            chk("bit_cnt",    int'(bit_cnt),     int'(x[PW+BW-1:PW]));
            chk("EdgeFinish", int'(edge_finish), int'(x[PW+BW]));
            chk("FINISH",     int'(finish),      int'(x[PW+BW+1]));
            chk("samp_strb",  int'(samp_strb),   int'(x[PW+BW+2]));
            chk("presc_err",  int'(presc_err),   int'(x[PW+BW+3]));
        end
    end

    initial begin
        int p;
        int len;
        int mode;
        rst   = 1'b1;
        presc = PW'(8);
        een   = 1'b0;
        ben   = 1'b0;
        @(posedge clk);

        // reset state, then a first bit at P=8
        run(2, 1'b1, 8, 1'b0, 1'b0);
        run(2, 1'b0, 8, 1'b0, 1'b0);
        run(10, 1'b0, 8, 1'b1, 1'b0);
        run(2, 1'b0, 16, 1'b0, 1'b0);

        // full 8-bit frame at P=16, bit counter wraps
        run(8 * 16 + 4, 1'b0, 16, 1'b1, 1'b1);
        run(2, 1'b0, 8, 1'b0, 1'b0);

        // mid-frame prescale change ignored until the next idle cycle
        run(4, 1'b0, 8, 1'b1, 1'b1);
        run(20, 1'b0, 32, 1'b1, 1'b1);
        run(1, 1'b0, 32, 1'b0, 1'b0);
        run(70, 1'b0, 32, 1'b1, 1'b1);
        run(2, 1'b0, 8, 1'b0, 1'b0);

        // both enables drop exactly at edge P-1
        run(7 + 8, 1'b0, 8, 1'b1, 1'b1);
        run(3, 1'b0, 8, 1'b0, 1'b0);

        // reset mid-frame with enables high
        run(2, 1'b0, 16, 1'b0, 1'b0);
        run(3 * 16 + 5, 1'b0, 16, 1'b1, 1'b1);
        run(1, 1'b1, 16, 1'b1, 1'b1);
        run(20, 1'b0, 16, 1'b1, 1'b1);
        run(2, 1'b0, 4, 1'b0, 1'b0);

`ifdef EBC_PRESC_CHECK_EN
        // illegal prescale falls back to the default; legal load clears it
        run(2, 1'b0, 7, 1'b0, 1'b0);
        run(20, 1'b0, 7, 1'b1, 1'b1);
        run(2, 1'b0, 4, 1'b0, 1'b0);
        run(12, 1'b0, 4, 1'b1, 1'b1);
        run(1, 1'b0, 4, 1'b0, 1'b0);
`endif

        // random frames
        for (int s = 0; s < 60; s++) begin
            p = pick_presc();
            run(int'($urandom_range(1, 3)), 1'b0, p, 1'b0, $urandom_range(0, 1) == 0);
            len  = int'($urandom_range(1, 200));
            mode = int'($urandom_range(0, 3));
            for (int k = 0; k < len; k++) begin
                cycle($urandom_range(0, 199) == 0,
                      ($urandom_range(0, 3) == 0) ? pick_presc() : p,
                      1'b1,
                      (mode != 0) ? 1'b1 : ($urandom_range(0, 1) == 1));
            end
        end
        run(2, 1'b0, 8, 1'b0, 1'b0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected beats left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
